// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: ASCII codes, dump FSM states, baud helper.
// Dump prefixing is selected by the DUMP_INDEX_EN macro in stash_uart_dump.
package stopwatch_pkg;

  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] A     = 8'h41;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    ADVANCE,
    SETTLE,
    DRAIN,
    FINISH
  } state_t;

  function automatic int baud_div(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  function automatic logic [7:0] hex_char(
    input logic [3:0] n
  );
    if (n < 4'd10)
      return ZERO + {4'd0, n};
    else
      return A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/byte_if.sv
// Valid/ready byte channel between the dump FSM and the UART.
// A byte moves on any cycle where valid && ready.
interface byte_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport src (output valid, output data, input ready);
  modport snk (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, BAUD_DIV clocks per bit.
// ready rises on the stop bit's last clock so frames chain gap-free.
module uart_tx_byte #(
  parameter int BAUD_DIV = 868
) (
  input  logic clk,
  input  logic reset_n,
  byte_if.snk  bus,
  output logic tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] baud_cnt;
  logic          active;
  logic          tick;
  logic          last;

  assign tick      = baud_cnt == CW'(BAUD_DIV - 1);
  assign last      = tick && (bit_cnt == 4'd9);
  assign bus.ready = !active || last;
  assign tx        = active ? shreg[0] : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      active   <= 1'b0;
    end else if (bus.valid && bus.ready) begin
      shreg    <= {1'b1, bus.data, 1'b0};
      bit_cnt  <= '0;
      baud_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (tick) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {1'b1, shreg[9:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stash_uart_dump.sv
// Walks DEPTH stash entries and sends them as ASCII over the UART.
// DUMP_INDEX_EN prefixes each sample with "<index>:".
module stash_uart_dump
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] sample_in,
  output logic       next_sample,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int BDIV = baud_div(CLK_FREQ, BAUD);
`ifdef DUMP_INDEX_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif

  state_t     state;
  state_t     state_nx;
  logic [7:0] smp;
  logic [2:0] ci;
  logic [2:0] rel;
  logic [2:0] last_ci;
  logic [3:0] scnt;
  logic       settle_q;
  logic       last_smp;
  logic [7:0] ch;

  byte_if bus ();

  uart_tx_byte #(
    .BAUD_DIV (BDIV)
  ) u_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .tx      (tx)
  );

  assign last_smp = scnt == 4'(DEPTH - 1);
  assign last_ci  = 3'(PRE + 2) + {2'b0, last_smp};
  assign rel      = ci - 3'(PRE);
  assign bus.data = ch;
  assign busy     = (state != IDLE) && (state != FINISH);

  // Character position within the current sample's field.
  always_comb begin
    ch = LF;
    unique case (1'b1)
      rel == 3'd0: ch = hex_char(smp[7:4]);
      rel == 3'd1: ch = hex_char(smp[3:0]);
      rel == 3'd2: ch = last_smp ? CR : COMMA;
      default:     ch = LF;
    endcase
`ifdef DUMP_INDEX_EN
    if (ci == 3'd0)
      ch = ZERO + {4'd0, scnt};
    else if (ci == 3'd1)
      ch = COLON;
`endif
  end

  always_comb begin
    state_nx    = state;
    bus.valid   = 1'b0;
    next_sample = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND: begin
        bus.valid = 1'b1;
        if (bus.ready && ci == last_ci)
          state_nx = ADVANCE;
      end
      ADVANCE: begin
        next_sample = 1'b1;
        state_nx    = SETTLE;
      end
      SETTLE:
        if (settle_q)
          state_nx = (scnt < 4'(DEPTH)) ? LOAD : DRAIN;
      DRAIN:   if (bus.ready) state_nx = FINISH;
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      smp      <= '0;
      ci       <= '0;
      scnt     <= '0;
      settle_q <= 1'b0;
    end else begin
      state    <= state_nx;
      settle_q <= (state == SETTLE) && !settle_q;
      if (state == IDLE)
        scnt <= '0;
      if (state == LOAD) begin
        smp <= sample_in;
        ci  <= '0;
      end
      if (state == SEND && bus.ready)
        ci <= ci + 3'd1;
      if (state == ADVANCE)
        scnt <= scnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_stash_uart_dump.sv
// Directed bench for stash_uart_dump: UART decode, pulse counts, timing.
// Build with +define+DUMP_INDEX_EN to check the indexed line format.
module tb_stash_uart_dump;

  localparam int DEPTH = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] sample_in;
  logic       next_sample;
  logic       busy;
  logic       done;
  logic       tx;

  always #5 clk = ~clk;

  stash_uart_dump #(
    .CLK_FREQ (1000),
    .BAUD     (100),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .sample_in   (sample_in),
    .next_sample (next_sample),
    .busy        (busy),
    .done        (done),
    .tx          (tx)
  );

  logic [7:0] mem [DEPTH];
  int         ptr = 0;

  assign sample_in = mem[ptr];

  always @(posedge clk)
    if (next_sample)
      ptr <= (ptr == DEPTH - 1) ? 0 : ptr + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef DUMP_INDEX_EN
  string exp1 = "0:12,1:05,2:30,3:47,4:59\015\012";
  string exp2 = "0:AF,1:00,2:9A,3:FF,4:10\015\012";
`else
  string exp1 = "12,05,30,47,59\015\012";
  string exp2 = "AF,00,9A,FF,10\015\012";
`endif

  int         cyc = 0;
  bit         rx_on = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_b = '0;
  logic [7:0] rx_q [$];
  int         last_fs = 0;
  int         ns_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         busy_cnt = 0;
  int         first_busy = -1;
  logic       tr [100];

  // UART decoder and activity counters, sampled on falling edges.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      rx_on = 1'b0;
    end else begin
      if (next_sample) ns_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (!rx_on) begin
        if (tx == 1'b0) begin
          rx_on   = 1'b1;
          rx_t    = 0;
          last_fs = cyc;
        end
      end else begin
        rx_t++;
      end
      if (rx_on) begin
        if (rx_q.size() == 0) tr[rx_t] = tx;
        if (rx_t % 10 == 5 && rx_t >= 15 && rx_t <= 85)
          rx_b[3'(rx_t / 10 - 1)] = tx;
        if (rx_t == 95) chk("stop_bit", 32'(tx), 32'd1);
        if (rx_t == 99) begin
          rx_on = 1'b0;
          rx_q.push_back(rx_b);
        end
      end
    end
  end

  task automatic run_dump(input bit extra, input string es,
                          input string nm);
    bit         seen = 1'b0;
    bit         did = 1'b0;
    int         lat = -1;
    int         nb = es.len();
    logic [7:0] g;
    rx_q.delete();
    ns_cnt     = 0;
    done_cnt   = 0;
    busy_cnt   = 0;
    first_busy = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 200 * nb && !seen; i++) begin
      @(negedge clk);
      if (lat < 0 && tx == 1'b0) lat = i;
      if (done) begin
        seen  = 1'b1;
        start = extra;
      end else if (extra && !did && rx_q.size() == 3) begin
        start = 1'b1;
        did   = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_nbytes"}, 32'(rx_q.size()), 32'(nb));
    for (int i = 0; i < nb; i++) begin
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", nm, i), 32'(g), 32'(es.getc(i)));
    end
    chk({nm, "_next_pulses"}, 32'(ns_cnt), 32'(DEPTH));
    chk({nm, "_ptr_home"}, 32'(ptr), 32'd0);
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, "_done_gap"}, 32'(done_cyc - last_fs), 32'd100);
    chk({nm, "_busy_len"}, 32'(busy_cnt),
        32'(last_fs + 100 - first_busy));
    chk({nm, "_latency"}, 32'(lat >= 1 && lat <= 4), 32'd1);
  endtask

  logic [9:0] fr;

  initial begin
    mem = '{8'h12, 8'h05, 8'h30, 8'h47, 8'h59};
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_next", 32'(next_sample), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
    chk("midrst_frame_began", 32'(tx), 32'd0);
    repeat (45) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_next", 32'(next_sample), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_dump(1'b1, exp1, "full");
    fr = {1'b1, exp1.getc(0), 1'b0};
    for (int k = 0; k < 100; k++)
      chk($sformatf("bit_t%0d", k), 32'(tr[k]), 32'(fr[k / 10]));

    mem = '{8'hAF, 8'h00, 8'h9A, 8'hFF, 8'h10};
    run_dump(1'b0, exp2, "hex");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stash_uart_dump.md
Name: stash_uart_dump

Overview:
Reader at the far end of the stash. On a start pulse it walks all DEPTH stash entries via next_sample/sample_out, formats each {dasec,sec} byte as ASCII, and transmits the line over an 8N1 UART (tx pin).
Sits beside the stash in the stopwatch top. start comes from a debounced button pulse.
The stash read pointer ends where it began, because DEPTH advances on a circular stash is a full cycle.

Parameters:
CLK_FREQ, 100000000, system clock in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD, truncated (868 at defaults)
DEPTH, 5, number of stash entries dumped per start (1..9)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a dump when idle
sample_in  input  8  stash current sample {dasec[3:0], sec[3:0]}
next_sample  output  1  one-cycle pulse advancing the stash read pointer
busy  output  1  high from accepted start through last stop bit
done  output  1  one-cycle pulse after final stop bit
tx  output  1  UART serial out, idle high

Behaviour:
- Reset (async, reset_n=0) values: tx=1, busy=0, next_sample=0, done=0; FSM to IDLE; bit/baud counters cleared. Reset mid-frame aborts immediately: tx high, with no partial stop bit.
- FSM states:
  - IDLE: start=1 -> LOAD, busy=1 next cycle.
  - LOAD: latch sample_in, char index=0.
  - SEND: present next char to byte TX; wait for its ready.
  - ADVANCE: next_sample=1 for exactly one cycle.
  - SETTLE: 2 cycles, to cover stash output latency.
  - Sample count < DEPTH -> LOAD; else -> FINISH.
  - FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Per-sample characters: hi-nibble digit, lo-nibble digit, then separator.
  - Separator is ',' (0x2C) for samples 0..DEPTH-2.
  - Last sample is followed by CR (0x0D), LF (0x0A).
  - Total bytes per dump = 3*DEPTH+1 (16 at default).
- Digit map: nibble 0-9 -> 0x30+n; nibble A-F -> 0x41+n-10.
- Sampling: sample_in is captured in LOAD only. Changes elsewhere are ignored.
- next_sample pulses after each sample's characters are queued, including the last. That gives exactly DEPTH pulses per dump.
- UART frame (8N1, LSB first):
  - start bit 0, 8 data bits, stop bit 1.
  - Each bit lasts exactly BAUD_DIV clocks.
  - Back-to-back bytes follow with no idle gap.
- start while busy=1: ignored, no queuing. start in the same cycle as done: ignored.
- Start-to-tx latency: first start bit drives tx low no later than 4 clocks after start is sampled.

Optional Feature:
Macro DUMP_INDEX_EN.
- Defined: each sample is prefixed with its index digit ('0'+i) and ':' (0x3A). Bytes per dump = 5*DEPTH+1.
- Undefined: no prefix; prefix logic is absent.

Decomposition:
Shared package stopwatch_pkg holds:
- ASCII constants: COMMA, COLON, CR, LF, ZERO, A.
- FSM state enum.
- Function for BAUD_DIV from CLK_FREQ and BAUD.
One sub-module, uart_tx_byte:
- Contains the baud counter and 10-bit shift register.
- Handshake is valid/ready. A byte is accepted when valid && ready; ready drops the next cycle.
- ready returns high at the end of the stop bit.

Test Plan:
Bench uses CLK_FREQ=1000, BAUD=100, so BAUD_DIV=10 and one frame = 100 clocks.
1. Reset: pulse reset_n low at clock 45 of a frame -> tx=1 that cycle; busy=0, next_sample=0, done=0; next start works normally.
2. Full dump:
   - Stimulus: stash model holds 0x12, 0x05, 0x30, 0x47, 0x59; one start pulse.
   - Required: decoded bytes "12,05,30,47,59\r\n" (0x31 0x32 0x2C ... 0x0D 0x0A), 16 bytes.
   - Required: exactly 5 next_sample pulses; done once, 1 clock after final stop bit.
3. Bit timing on first byte 0x31:
   - Required: tx low for 10 clocks (start bit).
   - Required: then data bits 1,0,0,0,1,1,0,0 at 10 clocks each.
   - Required: then high for 10 clocks (stop bit).
4. Start handling: second start pulse at byte 3 and at the done cycle -> no extra bytes, no extra next_sample, busy timeline unchanged.
5. Hex mapping: sample 0xAF -> bytes 0x41, 0x46.
6. DUMP_INDEX_EN defined, same data as scenario 2 -> "0:12,1:05,2:30,3:47,4:59\r\n", 26 bytes.
